// File: rtl/atm_pkg.sv
// Shared ATM controller types: FSM state encoding and op_sel command codes.
package atm_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_PIN,
    S_MENU,
    S_WITHDRAW,
    S_DEPOSIT,
    S_BALANCE,
    S_DISPENSE,
    S_DONE,
    S_RETAIN
  } state_t;

  localparam logic [1:0] OP_WITHDRAW = 2'd0;
  localparam logic [1:0] OP_DEPOSIT  = 2'd1;
  localparam logic [1:0] OP_BALANCE  = 2'd2;
  localparam logic [1:0] OP_CANCEL   = 2'd3;

endpackage

// File: rtl/atm_timeout_ctr.sv
// Idle-cycle counter for the PIN/menu states; expired is high once the
// count has reached TIMEOUT while still enabled.
module atm_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/atm_controller.sv
// ATM session controller: PIN check with card retention, withdraw/deposit/
// balance handling on a saturating balance register, idle timeout.
module atm_controller
  import atm_pkg::*;
#(
  parameter int AMT_W     = 16,
  parameter int BAL_W     = 24,
  parameter int PIN_TRIES = 3,
  parameter int TIMEOUT   = 255,
  parameter int INIT_BAL  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_inserted,
  input  logic             pin_valid,
  input  logic             pin_correct,
  input  logic             op_valid,
  input  logic [1:0]       op_sel,
  input  logic [AMT_W-1:0] amount,
  output logic             dispense_cash,
  output logic             update_balance,
  output logic             print_receipt,
  output logic             insufficient_funds,
  output logic             eject_card,
  output logic             card_retained,
  output logic [BAL_W-1:0] balance,
  output logic             busy
);

  localparam int FAIL_W = $clog2(PIN_TRIES + 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(PIN_TRIES - 1);
  localparam logic [BAL_W-1:0]  BAL_MAX   = '1;

  state_t            state;
  logic              arm;
  logic [FAIL_W-1:0] fail_cnt;
  logic [AMT_W-1:0]  amt_q;
  logic [BAL_W-1:0]  bal_q;
  logic [BAL_W-1:0]  amt_ext;
  logic [BAL_W:0]    dep_sum;
  logic              in_wait;
  logic              tmr_clr;
  logic              tmr_expired;

  assign in_wait = (state == S_WAIT_PIN) || (state == S_MENU);
  // Held clear outside the waiting states, so every entry starts from zero.
  assign tmr_clr = !in_wait || pin_valid || op_valid;
  assign amt_ext = BAL_W'(amt_q);
  assign dep_sum = {1'b0, bal_q} + {1'b0, amt_ext};

  atm_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (in_wait),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= S_IDLE;
      arm                <= 1'b1;
      fail_cnt           <= '0;
      amt_q              <= '0;
      bal_q              <= BAL_W'(INIT_BAL);
      dispense_cash      <= 1'b0;
      update_balance     <= 1'b0;
      print_receipt      <= 1'b0;
      insufficient_funds <= 1'b0;
      eject_card         <= 1'b0;
    end else begin
      dispense_cash      <= 1'b0;
      update_balance     <= 1'b0;
      print_receipt      <= 1'b0;
      insufficient_funds <= 1'b0;
      eject_card         <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (card_inserted && arm) begin
            state    <= S_WAIT_PIN;
            fail_cnt <= '0;
          end
        end
        S_WAIT_PIN: begin
          if (!card_inserted) begin
            state <= S_IDLE;
          end else if (pin_valid) begin
            if (pin_correct) begin
              state <= S_MENU;
            end else begin
              fail_cnt <= fail_cnt + 1'b1;
              if (fail_cnt == FAIL_LAST) state <= S_RETAIN;
            end
          end else if (tmr_expired) begin
            state <= S_DONE;
          end
        end
        S_MENU: begin
          if (!card_inserted) begin
            state <= S_IDLE;
          end else if (op_valid) begin
            amt_q <= amount;
            unique case (op_sel)
              OP_WITHDRAW: state <= S_WITHDRAW;
              OP_DEPOSIT:  state <= S_DEPOSIT;
              OP_BALANCE:  state <= S_BALANCE;
              OP_CANCEL:   state <= S_DONE;
            endcase
          end else if (tmr_expired) begin
            state <= S_DONE;
          end
        end
        S_WITHDRAW: begin
          if (amt_q == '0 || amt_ext > bal_q) begin
            insufficient_funds <= 1'b1;
            state              <= S_MENU;
          end else begin
            bal_q          <= bal_q - amt_ext;
            update_balance <= 1'b1;
            state          <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          dispense_cash <= 1'b1;
          state         <= S_DONE;
        end
        S_DEPOSIT: begin
          bal_q          <= dep_sum[BAL_W] ? BAL_MAX : dep_sum[BAL_W-1:0];
          update_balance <= 1'b1;
          state          <= S_DONE;
        end
        S_BALANCE: begin
          print_receipt <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          eject_card <= 1'b1;
          arm        <= 1'b0;
          state      <= S_IDLE;
        end
        S_RETAIN: ;
        default: state <= S_IDLE;
      endcase

      // Card removal re-arms IDLE; overrides the DONE disarm in the same cycle.
      if (!card_inserted && state != S_RETAIN) arm <= 1'b1;
    end
  end

  assign balance       = bal_q;
  assign busy          = (state != S_IDLE);
  assign card_retained = (state == S_RETAIN);

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_atm_controller;

  localparam int AMT_W   = 16;
  localparam int BAL_W   = 16;
  localparam int TIMEOUT = 20;

  localparam logic [4:0] P_DISP  = 5'b10000;
  localparam logic [4:0] P_UPD   = 5'b01000;
  localparam logic [4:0] P_PRINT = 5'b00100;
  localparam logic [4:0] P_INSUF = 5'b00010;
  localparam logic [4:0] P_EJECT = 5'b00001;

  typedef struct {
    logic [4:0]       pulses;
    logic [BAL_W-1:0] bal;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             card_inserted, pin_valid, pin_correct, op_valid;
  logic [1:0]       op_sel;
  logic [AMT_W-1:0] amount;
  logic             dispense_cash, update_balance, print_receipt;
  logic             insufficient_funds, eject_card, card_retained, busy;
  logic [BAL_W-1:0] balance;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  atm_controller #(
    .AMT_W(AMT_W), .BAL_W(BAL_W), .PIN_TRIES(3), .TIMEOUT(TIMEOUT), .INIT_BAL(1000)
  ) dut (
    .clk(clk), .rst(rst), .card_inserted(card_inserted),
    .pin_valid(pin_valid), .pin_correct(pin_correct),
    .op_valid(op_valid), .op_sel(op_sel), .amount(amount),
    .dispense_cash(dispense_cash), .update_balance(update_balance),
    .print_receipt(print_receipt), .insufficient_funds(insufficient_funds),
    .eject_card(eject_card), .card_retained(card_retained),
    .balance(balance), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a pulse consumes one expected event.
  always @(negedge clk) begin
    logic [4:0] p;
    exp_t e;
    p = {dispense_cash, update_balance, print_receipt, insufficient_funds, eject_card};
    if (rst && p != 5'd0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {11'd0, p, balance}, 32'd0);
      end else begin
        e = sb.pop_front();
        check(e.name, {11'd0, p, balance}, {11'd0, e.pulses, e.bal});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [4:0] p, input logic [BAL_W-1:0] b, input string name);
    exp_t e;
    e.pulses = p;
    e.bal    = b;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic pin(input logic ok);
    pin_valid = 1'b1;
    pin_correct = ok;
    step(1);
    pin_valid = 1'b0;
    pin_correct = 1'b0;
  endtask

  task automatic op(input logic [1:0] sel, input logic [AMT_W-1:0] amt);
    op_valid = 1'b1;
    op_sel = sel;
    amount = amt;
    step(1);
    op_valid = 1'b0;
    amount = '0;
  endtask

  task automatic wait_drain(input int budget, output int ticks);
    ticks = 0;
    while (sb.size() != 0 && ticks < budget) begin
      step(1);
      ticks++;
    end
    if (sb.size() != 0) begin
      check("drain_budget", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic start_session();
    card_inserted = 1'b1;
    step(2);
  endtask

  task automatic end_session();
    card_inserted = 1'b0;
    step(2);
  endtask

  initial begin
    int t;
    rst = 1'b0; card_inserted = 1'b0; pin_valid = 1'b0; pin_correct = 1'b0;
    op_valid = 1'b0; op_sel = 2'd0; amount = '0;
    step(2);
    rst = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_retained", 32'(card_retained), 32'd0);
    check("reset_balance", 32'(balance), 32'd1000);

    // Overdraw and zero withdraw are refused, then a valid withdraw of 500.
    step(1);
    start_session();
    check("busy_wait_pin", 32'(busy), 32'd1);
    pin(1'b1);
    expect_ev(P_INSUF, 16'd1000, "wd1500_insuf");
    op(2'd0, 16'd1500);
    wait_drain(20, t);
    step(2);
    check("busy_menu_after_insuf", 32'(busy), 32'd1);
    expect_ev(P_INSUF, 16'd1000, "wd0_insuf");
    op(2'd0, 16'd0);
    wait_drain(20, t);
    expect_ev(P_UPD, 16'd500, "wd500_update");
    expect_ev(P_DISP, 16'd500, "wd500_dispense");
    expect_ev(P_EJECT, 16'd500, "wd500_eject");
    op(2'd0, 16'd500);
    wait_drain(20, t);
    check("idle_after_withdraw", 32'(busy), 32'd0);
    end_session();

    // Balance enquiry.
    start_session();
    pin(1'b1);
    expect_ev(P_PRINT, 16'd500, "bal_print");
    expect_ev(P_EJECT, 16'd500, "bal_eject");
    op(2'd2, 16'd0);
    wait_drain(20, t);
    end_session();

    // Withdraw exactly the whole balance.
    start_session();
    pin(1'b1);
    expect_ev(P_UPD, 16'd0, "wd_all_update");
    expect_ev(P_DISP, 16'd0, "wd_all_dispense");
    expect_ev(P_EJECT, 16'd0, "wd_all_eject");
    op(2'd0, 16'd500);
    wait_drain(20, t);
    end_session();

    // Deposit to 65000, then deposit 1000 saturates at 65535.
    start_session();
    pin(1'b1);
    expect_ev(P_UPD, 16'd65000, "dep_update");
    expect_ev(P_EJECT, 16'd65000, "dep_eject");
    op(2'd1, 16'd65000);
    wait_drain(20, t);
    end_session();
    start_session();
    pin(1'b1);
    expect_ev(P_UPD, 16'd65535, "dep_sat_update");
    expect_ev(P_EJECT, 16'd65535, "dep_sat_eject");
    op(2'd1, 16'd1000);
    wait_drain(20, t);
    end_session();

    // Two wrong PINs, then correct, then cancel.
    start_session();
    pin(1'b0);
    pin(1'b0);
    check("two_wrong_not_retained", 32'(card_retained), 32'd0);
    pin(1'b1);
    expect_ev(P_EJECT, 16'd65535, "cancel_eject");
    op(2'd3, 16'd0);
    wait_drain(20, t);
    end_session();

    // Card pulled in the same cycle as a withdraw request.
    start_session();
    pin(1'b1);
    card_inserted = 1'b0;
    op(2'd0, 16'd100);
    step(5);
    check("pull_card_idle", 32'(busy), 32'd0);
    check("pull_card_balance", 32'(balance), 32'd65535);

    // Idle timeout in the menu, then no re-entry while card stays in.
    start_session();
    pin(1'b1);
    expect_ev(P_EJECT, 16'd65535, "timeout_eject");
    wait_drain(TIMEOUT + 20, t);
    check("timeout_window", 32'(t >= TIMEOUT && t <= TIMEOUT + 5), 32'd1);
    step(10);
    check("no_reentry", 32'(busy), 32'd0);
    end_session();
    start_session();
    check("reentry_after_removal", 32'(busy), 32'd1);

    // Third wrong PIN retains the card; only reset releases it.
    pin(1'b0);
    pin(1'b0);
    pin(1'b0);
    @(negedge clk);
    check("retained", 32'(card_retained), 32'd1);
    card_inserted = 1'b0;
    step(1);
    op(2'd0, 16'd10);
    pin(1'b1);
    step(10);
    check("retained_held", 32'(card_retained), 32'd1);
    check("retained_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    @(negedge clk);
    check("retain_cleared", 32'(card_retained), 32'd0);
    check("reset_reload_balance", 32'(balance), 32'd1000);

    // Reset while the withdraw is being decided aborts it.
    step(1);
    start_session();
    pin(1'b1);
    op(2'd0, 16'd100);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    card_inserted = 1'b0;
    step(3);
    check("abort_balance", 32'(balance), 32'd1000);
    check("abort_idle", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_controller.md
ATM_CONTROLLER -- requirements
Module: atm_controller

Interface
REQ-001 SHALL have parameter AMT_W, default 16, width of transaction amount.
REQ-002 SHALL have parameter BAL_W, default 24, width of account balance (BAL_W >= AMT_W).
REQ-003 SHALL have parameter PIN_TRIES, default 3, wrong-PIN attempts before card retention.
REQ-004 SHALL have parameter TIMEOUT, default 255, idle cycles allowed in WAIT_PIN/MENU.
REQ-005 SHALL have parameter INIT_BAL, default 1000, balance loaded at reset.
REQ-006 SHALL have ports: clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 card_inserted  input  1  level, card present.
REQ-009 pin_valid  input  1  one-cycle strobe, PIN entry complete; pin_correct  input  1  qualified by pin_valid.
REQ-010 op_valid  input  1  strobe; op_sel  input  2  0 withdraw, 1 deposit, 2 balance, 3 cancel.
REQ-011 amount  input  AMT_W  unsigned, sampled with op_valid.
REQ-012 dispense_cash, update_balance, print_receipt, insufficient_funds, eject_card  output  1 each  one-cycle registered pulses.
REQ-013 card_retained  output  1  level; balance  output  BAL_W  current balance; busy  output  1  high when state != IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT_PIN, MENU, WITHDRAW, DEPOSIT, BALANCE, DISPENSE, DONE, RETAIN.
REQ-015 IDLE: card_inserted=1 and arm=1 -> WAIT_PIN, fail count cleared, timer cleared; arm clears while card present after DONE, sets when card_inserted=0.
REQ-016 WAIT_PIN: pin_valid&pin_correct -> MENU; pin_valid&!pin_correct -> fail+1, stay; fail reaching PIN_TRIES -> RETAIN.
REQ-017 MENU: op_valid decodes op_sel: 0 -> WITHDRAW, 1 -> DEPOSIT, 2 -> BALANCE, 3 -> DONE; no op_valid -> stay.
REQ-018 WITHDRAW (1 cycle): amount==0 or amount>balance -> insufficient_funds pulse, back to MENU, balance unchanged; else balance -= amount, update_balance pulse, -> DISPENSE.
REQ-019 DISPENSE (1 cycle): dispense_cash pulse, -> DONE.
REQ-020 DEPOSIT (1 cycle): balance += amount, saturating at 2^BAL_W-1; update_balance pulse; -> DONE.
REQ-021 BALANCE (1 cycle): print_receipt pulse; -> DONE.
REQ-022 DONE (1 cycle): eject_card pulse; -> IDLE.
REQ-023 RETAIN: card_retained=1; no exit except reset; all inputs ignored.
REQ-024 Timer counts cycles in WAIT_PIN/MENU, cleared on state entry and on any pin_valid/op_valid; reaching TIMEOUT -> DONE.
REQ-025 card_inserted=0 in WAIT_PIN or MENU -> IDLE, no eject_card, takes priority over pin_valid/op_valid/timeout same cycle.
REQ-026 op_valid or pin_valid in same cycle as timeout expiry: strobe wins, timeout ignored.
REQ-027 Output pulses SHALL assert in the cycle following the transition-deciding edge, exactly one cycle wide; at most one of dispense_cash/insufficient_funds per withdraw.
REQ-028 op_valid/pin_valid outside MENU/WAIT_PIN respectively SHALL be ignored.

Reset
REQ-029 rst=0 at a clock edge: state IDLE, arm=1, fail=0, timer=0, balance=INIT_BAL, all pulse outputs 0, card_retained=0, busy=0.
REQ-030 Reset mid-transaction SHALL abort without balance update or pulses; reset dominates all inputs.

Structure
REQ-031 Shared package atm_pkg SHALL hold the state enum and op_sel code constants.
REQ-032 Timeout counter SHALL be a sub-module atm_timeout_ctr (param TIMEOUT; inputs clr, en; output expired).

Verification
REQ-033 Card, correct PIN, withdraw 500 from 1000 -> update_balance, then dispense_cash, eject_card pulses; balance=500.
REQ-034 Withdraw 1500 with balance 1000 -> insufficient_funds pulse, back to MENU, balance=1000, no dispense_cash.
REQ-035 Three wrong PINs (PIN_TRIES=3) -> RETAIN, card_retained=1 held; only rst=0 clears it.
REQ-036 BAL_W=16, balance 65000, deposit 1000 -> balance=65535, update_balance pulse.
REQ-037 Card in, correct PIN, no op for TIMEOUT cycles -> eject_card pulse, IDLE; no re-entry until card_inserted drops.
REQ-038 Card removed same cycle as op_valid in MENU -> IDLE, no pulses, balance unchanged.
